alu_mul_sequencer: RTL

- Iterative shift-and-add multiplier that computes the low 32 bits of an unsigned 32x32 product (RV32M MUL, sign-agnostic for low word).
- Owns no adder: it sequences the shared ALU, driving its control and operand ports with ADD (ctl 7'b0000010) through a request/grant port.
- The execute stage keeps priority on the ALU.
- Sits beside the ALU in execute; the pipeline stalls on req_ready/resp_valid.

---
 rtl/alu_mul_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/alu_mul_sequencer.sv
// Iterative shift-and-add multiplier (low 32 bits of a 32x32 product) that borrows
// the shared execute-stage ALU for its additions through a request/grant handshake.
module alu_mul_sequencer #(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        alu_req,
  input  logic        alu_grant,
  output logic [6:0]  alu_ctl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [6:0] ALU_ADD = 7'b0000010;

  logic [1:0]  state_r,    state_nxt_s;
  logic [31:0] acc_r,      acc_nxt_s;
  logic [31:0] mcand_r,    mcand_nxt_s;
  logic [31:0] mplier_r,   mplier_nxt_s;
  logic [5:0]  step_cnt_r, step_cnt_nxt_s;
  logic        last_step_s;
  logic        run_s;

  // Next-state and datapath update; flush overrides every other event.
  always_comb begin
    state_nxt_s    = state_r;
    acc_nxt_s      = acc_r;
    mcand_nxt_s    = mcand_r;
    mplier_nxt_s   = mplier_r;
    step_cnt_nxt_s = step_cnt_r;
    last_step_s    = 1'b0;
    if (EARLY_EXIT) begin
      last_step_s = (mplier_r[31:1] == 31'd0);
    end else begin
      last_step_s = (step_cnt_r == 6'd31);
    end
    if (flush) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            acc_nxt_s      = 32'd0;
            mcand_nxt_s    = req_a;
            mplier_nxt_s   = req_b;
            step_cnt_nxt_s = 6'd0;
            state_nxt_s    = ST_RUN;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          // An exhausted multiplier finishes without waiting for the ALU.
          if (EARLY_EXIT && (mplier_r == 32'd0)) begin
            state_nxt_s = ST_DONE;
          end else if (alu_grant) begin
            if (mplier_r[0]) begin
              acc_nxt_s = alu_out;
            end else begin
              acc_nxt_s = acc_r;
            end
            mcand_nxt_s    = {mcand_r[30:0], 1'b0};
            mplier_nxt_s   = {1'b0, mplier_r[31:1]};
            step_cnt_nxt_s = step_cnt_r + 6'd1;
            if (last_step_s) begin
              state_nxt_s = ST_DONE;
            end else begin
              state_nxt_s = ST_RUN;
            end
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      acc_r      <= 32'd0;
      mcand_r    <= 32'd0;
      mplier_r   <= 32'd0;
      step_cnt_r <= 6'd0;
    end else begin
      state_r    <= state_nxt_s;
      acc_r      <= acc_nxt_s;
      mcand_r    <= mcand_nxt_s;
      mplier_r   <= mplier_nxt_s;
      step_cnt_r <= step_cnt_nxt_s;
    end
  end

  // Outputs decode only registered state, so they are glitch-free and reset asynchronously.
  assign run_s      = (state_r == ST_RUN);
  assign req_ready  = (state_r == ST_IDLE);
  assign resp_valid = (state_r == ST_DONE);
  assign resp_data  = (state_r == ST_DONE) ? acc_r : 32'd0;
  assign alu_req    = run_s;
  assign alu_ctl    = run_s ? ALU_ADD : 7'd0;
  assign alu_a      = run_s ? acc_r : 32'd0;
  assign alu_b      = run_s ? mcand_r : 32'd0;
  assign busy       = (state_r != ST_IDLE);

endmodule
